button_reader: RTL and testbench



---
 rtl/button_reader_if.sv | 28 ++
 rtl/button_reader.sv | 143 ++++++++++++++
 tb/tb_button_reader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/button_reader_if.sv
// Pushbutton conditioner bus: the raw pin in, and the
// debounced level, press/release/long-press events and press count out.
interface button_reader_if;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press_pulse;
  logic [3:0] press_count;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_press_pulse,
    input  press_count
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_press_pulse,
    output press_count
  );
endinterface

// File: rtl/button_reader.sv
// Pushbutton conditioner: 2-flop sync, two-edge debounce FSM,
// long-press detect and a wrapping 4-bit press counter.
module button_reader #(
  parameter int DEBOUNCE_CYCLES   = 200000,
  parameter int LONG_PRESS_CYCLES = 8000000,
  parameter int ACTIVE_LOW        = 1
) (
  input logic            clk,
  input logic            rst,
  button_reader_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic PIN_IDLE = (ACTIVE_LOW != 0);
  // The cycle that enters a wait state already saw p stable,
  // so the wait ends one count early to hit DEBOUNCE_CYCLES total.
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    HELD,
    RELEASE_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          held_q, held_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          p;

  assign p = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];

  // Next-state: synchronizer shift plus debounce/hold state machine.
  always_comb begin
    sync_d  = {sync_q[0], bus.btn_in};
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    held_d  = held_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (p) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_d = IDLE;
        end else if (dcnt_q == D_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
          level_d = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          hcnt_d  = '0;
          held_d  = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!p) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end else if (hcnt_q == H_LAST) begin
          state_d = HELD;
          long_d  = 1'b1;
          held_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!p) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_d = held_q ? HELD : PRESSED;
        end else if (dcnt_q == D_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          level_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset returns pin sync to idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {2{PIN_IDLE}};
      state_q <= IDLE;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      held_q  <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      held_q  <= held_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.btn_level        = level_q;
  assign bus.press_pulse      = press_q;
  assign bus.release_pulse    = rel_q;
  assign bus.long_press_pulse = long_q;
  assign bus.press_count      = cnt_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with short debounce/hold
// parameters; edges counted from the pin change.
module tb_button_reader;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   seen;
  logic lvl_min;
  logic any_evt;

  button_reader_if bus ();

  button_reader #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(10),
    .ACTIVE_LOW       (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    edges(2);
    rst = 1'b0;
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, {bus.btn_level, bus.press_pulse,
              bus.release_pulse, bus.long_press_pulse}, 4'h0);
    chk({tag, "_cnt"}, bus.press_count, 4'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.btn_in = 1'b1;
    edges(3);
    rst = 1'b0;

    // reset state, idle pin for 20 cycles
    outs_zero("reset");
    for (int i = 0; i < 20; i++) begin
      edges(1);
      outs_zero("idle");
    end

    // clean press: pulse after edge 6
    bus.btn_in = 1'b0;
    edges(5);
    chk("press_e5_pulse", {3'b0, bus.press_pulse}, 4'h0);
    chk("press_e5_lvl", {3'b0, bus.btn_level}, 4'h0);
    edges(1);
    chk("press_e6_pulse", {3'b0, bus.press_pulse}, 4'h1);
    chk("press_e6_lvl", {3'b0, bus.btn_level}, 4'h1);
    chk("press_e6_cnt", bus.press_count, 4'h1);
    edges(1);
    chk("press_e7_pulse", {3'b0, bus.press_pulse}, 4'h0);
    chk("press_e7_lvl", {3'b0, bus.btn_level}, 4'h1);

    // long press at edge 16
    edges(8);
    chk("long_e15", {3'b0, bus.long_press_pulse}, 4'h0);
    edges(1);
    chk("long_e16", {3'b0, bus.long_press_pulse}, 4'h1);
    seen = 0;
    for (int i = 17; i <= 30; i++) begin
      edges(1);
      seen += int'(bus.long_press_pulse);
    end
    chk("long_once", 4'(seen), 4'h0);
    chk("long_lvl", {3'b0, bus.btn_level}, 4'h1);

    // release: pulse after edge 6 of release
    bus.btn_in = 1'b1;
    edges(5);
    chk("rel_e5_pulse", {3'b0, bus.release_pulse}, 4'h0);
    chk("rel_e5_lvl", {3'b0, bus.btn_level}, 4'h1);
    edges(1);
    chk("rel_e6_pulse", {3'b0, bus.release_pulse}, 4'h1);
    chk("rel_e6_lvl", {3'b0, bus.btn_level}, 4'h0);
    edges(1);
    chk("rel_e7_pulse", {3'b0, bus.release_pulse}, 4'h0);
    chk("rel_cnt", bus.press_count, 4'h1);

    // press then a 2-cycle release bounce
    bus.btn_in = 1'b0;
    edges(6);
    chk("p2_pulse", {3'b0, bus.press_pulse}, 4'h1);
    chk("p2_cnt", bus.press_count, 4'h2);
    edges(2);
    bus.btn_in = 1'b1;
    edges(2);
    bus.btn_in = 1'b0;
    seen    = 0;
    lvl_min = 1'b1;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      seen += int'(bus.release_pulse);
      lvl_min &= bus.btn_level;
    end
    chk("bounce_rel", 4'(seen), 4'h0);
    chk("bounce_lvl", {3'b0, lvl_min}, 4'h1);
    bus.btn_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      seen += int'(bus.release_pulse);
    end
    chk("clean_rel_once", 4'(seen), 4'h1);
    chk("clean_rel_lvl", {3'b0, bus.btn_level}, 4'h0);
    chk("clean_rel_cnt", bus.press_count, 4'h2);

    // 3-cycle glitch on idle pin after a fresh reset
    do_reset();
    outs_zero("reset2");
    bus.btn_in = 1'b0;
    edges(3);
    bus.btn_in = 1'b1;
    any_evt = 1'b0;
    lvl_min = 1'b0;
    for (int i = 0; i < 12; i++) begin
      edges(1);
      any_evt |= bus.press_pulse | bus.release_pulse
               | bus.long_press_pulse;
      lvl_min |= bus.btn_level;
    end
    chk("glitch_evt", {3'b0, any_evt}, 4'h0);
    chk("glitch_lvl", {3'b0, lvl_min}, 4'h0);
    chk("glitch_cnt", bus.press_count, 4'h0);

    // 17 clean presses wrap the counter to 1
    for (int i = 1; i <= 17; i++) begin
      bus.btn_in = 1'b0;
      edges(8);
      bus.btn_in = 1'b1;
      edges(8);
      if (i == 15) chk("cnt_15", bus.press_count, 4'hf);
      if (i == 16) chk("cnt_wrap0", bus.press_count, 4'h0);
    end
    chk("cnt_wrap1", bus.press_count, 4'h1);

    // reset at edge 4 of a press debounce
    bus.btn_in = 1'b0;
    edges(3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    outs_zero("mid_rst");
    edges(2);
    rst = 1'b0;
    edges(5);
    chk("fresh_e5_pulse", {3'b0, bus.press_pulse}, 4'h0);
    chk("fresh_e5_cnt", bus.press_count, 4'h0);
    edges(1);
    chk("fresh_e6_pulse", {3'b0, bus.press_pulse}, 4'h1);
    chk("fresh_e6_lvl", {3'b0, bus.btn_level}, 4'h1);
    chk("fresh_e6_cnt", bus.press_count, 4'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
